// File: rtl/alu_apb_arbiter_if.sv
// alu_apb_arbiter_if: APB bus between the arbiter (master) and the ALU register slave
interface alu_apb_arbiter_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/alu_apb_arbiter.sv
// alu_apb_arbiter: round-robin APB master sharing the ALU register port between two requesters
module alu_apb_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'd15,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [31:0]       req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              req0_ack,
    output logic              req0_done,
    output logic [31:0]       req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [31:0]       req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              req1_ack,
    output logic              req1_done,
    output logic [31:0]       req1_rdata,
    output logic              req1_err,
    alu_apb_arbiter_if.master apb
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t      state, state_n;
    logic        last_grant, grant, pick, start, owner, illegal, timeout_hit, sel_write, resp_err;
    logic [31:0] sel_addr, sel_wdata, resp_rdata, cnt;
    always_comb begin
        pick        = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        sel_write   = pick ? req1_write : req0_write;
        sel_addr    = pick ? req1_addr : req0_addr;
        sel_wdata   = pick ? req1_wdata : req0_wdata;
        illegal     = sel_addr > ADDR_LIMIT;
        timeout_hit = TIMEOUT != 0 && !apb.pready && cnt == TIMEOUT - 1;
        start       = state == IDLE && (req0_valid || req1_valid);
        owner       = start ? pick : grant;
        // Any response not produced by a completed ACCESS is an illegal address or an abort
        resp_err    = (state == ACCESS && apb.pready) ? apb.pslverr : 1'b1;
        resp_rdata  = (state == ACCESS && apb.pready && !apb.pwrite) ? apb.prdata : '0;
        state_n     = state;
        case (state)
            IDLE:   state_n = start ? (illegal ? RESP : SETUP) : IDLE;
            SETUP:  state_n = ACCESS;
            ACCESS: state_n = (apb.pready || timeout_hit) ? RESP : ACCESS;
            RESP:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            cnt         <= '0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            req0_ack    <= 1'b0;
            req0_done   <= 1'b0;
            req0_err    <= 1'b0;
            req0_rdata  <= '0;
            req1_ack    <= 1'b0;
            req1_done   <= 1'b0;
            req1_err    <= 1'b0;
            req1_rdata  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= (state == ACCESS && state_n == ACCESS) ? cnt + 1 : '0;
            apb.psel    <= state_n == SETUP || state_n == ACCESS;
            apb.penable <= state_n == ACCESS;
            req0_ack    <= start && !pick;
            req1_ack    <= start && pick;
            req0_done   <= state_n == RESP && !owner;
            req1_done   <= state_n == RESP && owner;
            if (start) begin
                grant      <= pick;
                last_grant <= pick;
            end
            if (start && !illegal) begin
                apb.pwrite <= sel_write;
                apb.paddr  <= sel_addr;
                apb.pwdata <= sel_wdata;
            end
            if (state_n == RESP && !owner) {req0_err, req0_rdata} <= {resp_err, resp_rdata};
            if (state_n == RESP && owner) {req1_err, req1_rdata} <= {resp_err, resp_rdata};
        end
    end
endmodule

// File: tb/tb_alu_apb_arbiter.sv
// tb_alu_apb_arbiter: vector table, hand sequences and randomized model check of the APB arbiter
module tb_alu_apb_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req0_write, req0_ack, req0_done, req0_err;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_ack, req1_done, req1_err;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    int          wait_n = 0;
    int          pen_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          dn;
    bit          last_g = 1'b1;
    bit          pend[2];
    bit          cw[2];
    logic [31:0] ca[2], cd[2];

    typedef struct {
        bit          req;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] prd;
        bit          slverr;
        int          done_c;
        int          pen_n;
        bit          err;
        logic [31:0] rdata;
    } vec_t;
    vec_t v[10];

    alu_apb_arbiter_if apb ();

    alu_apb_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .apb(apb)
    );

    always #5 clk = ~clk;

    // Slave: pready stays low for wait_n ACCESS cycles of each transfer
    always @(posedge clk) pen_cnt <= (apb.penable && !apb.pready) ? pen_cnt + 1 : 0;
    assign apb.pready = pen_cnt >= wait_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        req0_valid = pend[0]; req0_write = cw[0]; req0_addr = ca[0]; req0_wdata = cd[0];
        req1_valid = pend[1]; req1_write = cw[1]; req1_addr = ca[1]; req1_wdata = cd[1];
    endtask

    task automatic put(input bit r, input bit wr, input logic [31:0] a, input logic [31:0] d);
        pend[r] = 1'b1; cw[r] = wr; ca[r] = a; cd[r] = d;
    endtask

    task automatic rnd_put(input bit r);
        put(r, 1'($urandom_range(1)), 32'($urandom_range(20)), $urandom);
    endtask

    // Starts in an IDLE cycle, runs one grant through done, returns in the following IDLE cycle
    task automatic xfer(input string tag, input bit w, input int done_exp, input int pen_exp,
                        input bit err_exp, input logic [31:0] rd_exp);
        int          ack_c = -1;
        int          done_c = -1;
        int          psel_c = -1;
        int          pen = 0;
        int          stray = 0;
        logic [31:0] o_rd = w ? req0_rdata : req1_rdata;
        logic        o_err = w ? req0_err : req1_err;
        logic        gap;
        drive();
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (req0_ack || req1_ack) begin
                if (ack_c < 0 && (w ? (req1_ack && !req0_ack) : (req0_ack && !req1_ack))) ack_c = c;
                else stray++;
                if (req0_ack) pend[0] = 1'b0;
                if (req1_ack) pend[1] = 1'b0;
                drive();
            end
            if (req0_done || req1_done) begin
                if (w ? (req1_done && !req0_done) : (req0_done && !req1_done)) done_c = c;
                else stray++;
            end
            if (apb.penable) pen++;
            if (apb.psel && psel_c < 0) begin
                psel_c = c;
                chk({tag, " paddr"}, apb.paddr, ca[w]);
                chk({tag, " pwrite"}, 32'(apb.pwrite), 32'(cw[w]));
                chk({tag, " pwdata"}, apb.pwdata, cd[w]);
            end
        end
        gap = apb.psel;
        chk({tag, " ack cycle"}, ack_c, 1);
        chk({tag, " done cycle"}, done_c, done_exp);
        chk({tag, " penable cycles"}, pen, pen_exp);
        chk({tag, " psel start"}, psel_c, pen_exp == 0 ? -1 : 1);
        chk({tag, " stray handshakes"}, stray, 0);
        chk({tag, " err"}, 32'(w ? req1_err : req0_err), 32'(err_exp));
        chk({tag, " rdata"}, w ? req1_rdata : req0_rdata, rd_exp);
        chk({tag, " other rdata held"}, w ? req0_rdata : req1_rdata, o_rd);
        chk({tag, " other err held"}, 32'(w ? req0_err : req1_err), 32'(o_err));
        @(posedge clk); #1;
        gap |= apb.psel;
        chk({tag, " psel gap"}, 32'(gap), 0);
        last_g = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v[0] = '{1'b0, 1'b1, 32'd6,  32'h9841C0C6, 0,    32'h0,        1'b0, 3,  1, 1'b0, 32'h0};
        v[1] = '{1'b1, 1'b0, 32'd2,  32'h0,        3,    32'hA5,       1'b0, 6,  4, 1'b0, 32'hA5};
        v[2] = '{1'b0, 1'b0, 32'd15, 32'h0,        0,    32'h12345678, 1'b0, 3,  1, 1'b0, 32'h12345678};
        v[3] = '{1'b1, 1'b1, 32'd3,  32'h55,       0,    32'hFFFFFFFF, 1'b1, 3,  1, 1'b1, 32'h0};
        v[4] = '{1'b0, 1'b0, 32'd4,  32'h0,        1000, 32'hDEADBEEF, 1'b0, 10, 8, 1'b1, 32'h0};
        v[5] = '{1'b1, 1'b0, 32'd20, 32'h0,        0,    32'h777,      1'b0, 1,  0, 1'b1, 32'h0};
        v[6] = '{1'b0, 1'b1, 32'd16, 32'h1,        0,    32'h0,        1'b0, 1,  0, 1'b1, 32'h0};
        v[7] = '{1'b1, 1'b0, 32'd5,  32'h0,        7,    32'h0BADF00D, 1'b0, 10, 8, 1'b0, 32'h0BADF00D};
        v[8] = '{1'b0, 1'b0, 32'd9,  32'h0,        2,    32'h00C0FFEE, 1'b1, 5,  3, 1'b1, 32'h00C0FFEE};
        v[9] = '{1'b0, 1'b1, 32'd0,  32'h4321,     2,    32'h1234,     1'b0, 5,  3, 1'b0, 32'h0};
        apb.prdata = '0;
        apb.pslverr = 1'b0;
        pend = '{1'b0, 1'b0};
        cw = '{1'b0, 1'b0};
        ca = '{32'h0, 32'h0};
        cd = '{32'h0, 32'h0};
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", 32'({apb.psel, apb.penable, apb.pwrite, req0_ack, req0_done, req0_err,
                              req1_ack, req1_done, req1_err}), 0);
        chk("reset paddr", apb.paddr, 0);
        chk("reset pwdata", apb.pwdata, 0);
        chk("reset rdata", req0_rdata | req1_rdata, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            wait_n = v[i].wait_n;
            apb.prdata = v[i].prd;
            apb.pslverr = v[i].slverr;
            put(v[i].req, v[i].write, v[i].addr, v[i].wdata);
            xfer($sformatf("vec%0d", i), v[i].req, v[i].done_c, v[i].pen_n, v[i].err, v[i].rdata);
        end
        // Round-robin from reset with both requesters always pending
        reset_n = 1'b0; #3; reset_n = 1'b1; last_g = 1'b1;
        @(posedge clk); #1;
        wait_n = 0;
        apb.pslverr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++) if (!pend[r]) put(r[0], 1'b1, 32'(r + 2 * i), $urandom);
            apb.prdata = $urandom;
            xfer($sformatf("rr%0d", i), i[0], 3, 1, 1'b0, 32'h0);
        end
        // Reset during ACCESS: bus drops at once, no done, requester 0 wins afterwards
        wait_n = 1000;
        put(1'b0, 1'b0, 32'd7, 32'h0);
        drive();
        @(posedge clk); #1;
        chk("mid ack0", 32'(req0_ack), 1);
        pend[0] = 1'b0;
        drive();
        repeat (2) begin @(posedge clk); #1; end
        chk("mid in access", 32'({apb.psel, apb.penable}), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid async drop", 32'({apb.psel, apb.penable}), 0);
        dn = 0;
        repeat (3) begin @(posedge clk); #1; dn += int'(req0_done | req1_done); end
        reset_n = 1'b1;
        last_g = 1'b1;
        wait_n = 0;
        repeat (3) begin @(posedge clk); #1; dn += int'(req0_done | req1_done); end
        chk("mid no done", dn, 0);
        put(1'b0, 1'b1, 32'd1, 32'hA);
        put(1'b1, 1'b1, 32'd2, 32'hB);
        xfer("post reset first", 1'b0, 3, 1, 1'b0, 32'h0);
        xfer("post reset second", 1'b1, 3, 1, 1'b0, 32'h0);
        // Random traffic against a rule-level model of grant, latency and response
        for (int i = 0; i < 40; i++) begin
            bit w, ill, tmo;
            int pen;
            for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(1) == 1) rnd_put(r[0]);
            if (!pend[0] && !pend[1]) rnd_put(1'($urandom_range(1)));
            wait_n = $urandom_range(9);
            apb.prdata = $urandom;
            apb.pslverr = $urandom_range(3) == 0;
            w = (pend[0] && pend[1]) ? !last_g : pend[1];
            ill = ca[w] > 15;
            tmo = wait_n >= 8;
            pen = ill ? 0 : (tmo ? 8 : wait_n + 1);
            xfer($sformatf("rnd%0d", i), w, ill ? 1 : pen + 2, pen, ill || tmo || apb.pslverr,
                 (ill || tmo || cw[w]) ? 32'h0 : apb.prdata);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
